// File: rtl/lc3_regfile_if.sv
// lc3_regfile_if: bundles the register file's write, condition-code and read-port signals
interface lc3_regfile_if #(
   parameter int NREG     = 8,
   parameter int SELSIZE  = 3,
   parameter int DATASIZE = 16
);
   logic                     ld_reg;
   logic [SELSIZE-1:0]       dr;
   logic [DATASIZE-1:0]      bus_in;
   logic                     ld_cc;
   logic [SELSIZE-1:0]       sr1;
   logic [SELSIZE-1:0]       sr2;
   logic [DATASIZE-1:0]      sr1_out;
   logic [DATASIZE-1:0]      sr2_out;
   logic [DATASIZE*NREG-1:0] regs_flat;
   logic                     n;
   logic                     z;
   logic                     p;
   modport master (
      output ld_reg, dr, bus_in, ld_cc, sr1, sr2,
      input  sr1_out, sr2_out, regs_flat, n, z, p
   );
   modport slave (
      input  ld_reg, dr, bus_in, ld_cc, sr1, sr2,
      output sr1_out, sr2_out, regs_flat, n, z, p
   );
endinterface

// File: rtl/lc3_regfile.sv
// lc3_regfile: NREG-entry register file with decoded write, N/Z/P codes and two combinational read ports
module lc3_regfile #(
   parameter int NREG     = 8,
   parameter int SELSIZE  = 3,
   parameter int DATASIZE = 16
) (
   input logic         clk,
   input logic         rst_n,
   lc3_regfile_if.slave rf
);
   logic [NREG-1:0][DATASIZE-1:0] r_regs;
   logic                          r_n;
   logic                          r_z;
   logic                          r_p;
   logic [DATASIZE-1:0]           w_sr1;
   logic [DATASIZE-1:0]           w_sr2;
   // decode dr into a one-hot load; selects with no matching register write nothing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_regs <= '0;
      else for (int i = 0; i < NREG; i++)
         if (rf.ld_reg && rf.dr == SELSIZE'(i)) r_regs[i] <= rf.bus_in;
   end
   // condition codes follow the bus value, not the written register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) {r_n, r_z, r_p} <= 3'b010;
      else if (rf.ld_cc) begin
         r_n <= rf.bus_in[DATASIZE-1];
         r_z <= rf.bus_in == '0;
         r_p <= !rf.bus_in[DATASIZE-1] && rf.bus_in != '0;
      end
   end
   // read muxes; unmatched selects fall through to zero
   always_comb begin
      w_sr1 = '0;
      w_sr2 = '0;
      for (int i = 0; i < NREG; i++) begin
         w_sr1 = rf.sr1 == SELSIZE'(i) ? r_regs[i] : w_sr1;
         w_sr2 = rf.sr2 == SELSIZE'(i) ? r_regs[i] : w_sr2;
      end
   end
   assign rf.sr1_out   = w_sr1;
   assign rf.sr2_out   = w_sr2;
   assign rf.regs_flat = r_regs;
   assign rf.n         = r_n;
   assign rf.z         = r_z;
   assign rf.p         = r_p;
endmodule

// File: tb/tb_lc3_regfile.sv
// tb_lc3_regfile: randomized and directed checks of lc3_regfile (NREG=8 and NREG=6) against an array model
module tb_lc3_regfile;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #20 clk = ~clk;

   lc3_regfile_if #(.NREG(8), .SELSIZE(3), .DATASIZE(16)) if8();
   lc3_regfile_if #(.NREG(6), .SELSIZE(3), .DATASIZE(16)) if6();

   assign if6.ld_reg = if8.ld_reg;
   assign if6.dr     = if8.dr;
   assign if6.bus_in = if8.bus_in;
   assign if6.ld_cc  = if8.ld_cc;
   assign if6.sr1    = if8.sr1;
   assign if6.sr2    = if8.sr2;

   lc3_regfile #(.NREG(8), .SELSIZE(3), .DATASIZE(16)) u8 (.clk(clk), .rst_n(rst_n), .rf(if8.slave));
   lc3_regfile #(.NREG(6), .SELSIZE(3), .DATASIZE(16)) u6 (.clk(clk), .rst_n(rst_n), .rf(if6.slave));

   int checks = 0;
   int passes = 0;
   int fails  = 0;
   logic [15:0] m8 [8];
   logic [15:0] m6 [8];
   logic [2:0]  mcc;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else begin
         fails++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) begin
         m8[i] = '0;
         m6[i] = '0;
      end
      mcc = 3'b010;
   endtask

   // one clock: the model applies the architectural rules to the inputs seen at the edge
   task automatic tick();
      @(posedge clk);
      if (if8.ld_reg) m8[if8.dr] = if8.bus_in;
      if (if8.ld_reg && int'(if8.dr) < 6) m6[if8.dr] = if8.bus_in;
      if (if8.ld_cc) mcc = if8.bus_in[15] ? 3'b100 : (if8.bus_in == 16'h0 ? 3'b010 : 3'b001);
      @(negedge clk);
   endtask

   task automatic check_state(input string tag);
      for (int i = 0; i < 8; i++)
         check($sformatf("%s_flat8_r%0d", tag, i), if8.regs_flat[i*16 +: 16], m8[i]);
      for (int i = 0; i < 6; i++)
         check($sformatf("%s_flat6_r%0d", tag, i), if6.regs_flat[i*16 +: 16], m6[i]);
      check({tag, "_cc8"}, {13'h0, if8.n, if8.z, if8.p}, {13'h0, mcc});
      check({tag, "_cc6"}, {13'h0, if6.n, if6.z, if6.p}, {13'h0, mcc});
      check({tag, "_onehot"}, 16'($countones({if8.n, if8.z, if8.p})), 16'd1);
   endtask

   task automatic check_reads(input string tag);
      for (int i = 0; i < 8; i++) begin
         if8.sr1 = 3'(i);
         if8.sr2 = 3'(7 - i);
         #1;
         check($sformatf("%s_sr1_8_r%0d", tag, i), if8.sr1_out, m8[i]);
         check($sformatf("%s_sr2_8_r%0d", tag, 7 - i), if8.sr2_out, m8[7-i]);
         check($sformatf("%s_sr1_6_r%0d", tag, i), if6.sr1_out, i < 6 ? m6[i] : 16'h0);
         check($sformatf("%s_sr2_6_r%0d", tag, 7 - i), if6.sr2_out, (7 - i) < 6 ? m6[7-i] : 16'h0);
      end
   endtask

   initial begin
      if8.ld_reg = 1'b0;
      if8.dr     = '0;
      if8.bus_in = '0;
      if8.ld_cc  = 1'b0;
      if8.sr1    = '0;
      if8.sr2    = '0;
      model_reset();
      repeat (2) @(negedge clk);
      check_state("reset");
      check_reads("reset");
      rst_n = 1'b1;
      // random traffic
      repeat (30) begin
         if8.ld_reg = 1'($urandom_range(0, 1));
         if8.dr     = 3'($urandom);
         if8.bus_in = 16'($urandom);
         if8.ld_cc  = 1'($urandom_range(0, 1));
         tick();
         check_state("rand");
      end
      check_reads("rand");
      // asynchronous reset pulse between edges
      if8.ld_reg = 1'b1;
      if8.dr     = 3'd1;
      if8.bus_in = 16'($urandom);
      #3 rst_n = 1'b0;
      model_reset();
      #1 check_state("arst");
      check_reads("arst");
      if8.ld_reg = 1'b0;
      if8.ld_cc  = 1'b0;
      rst_n = 1'b1;
      tick();
      check_state("arst_rel");
      // demux coverage
      for (int i = 0; i < 8; i++) begin
         if8.ld_reg = 1'b1;
         if8.dr     = 3'(i);
         if8.bus_in = 16'(16'h1111 * i + 1);
         tick();
         check_state($sformatf("demux%0d", i));
      end
      if8.ld_reg = 1'b0;
      check_reads("demux");
      // read during write: old value before the edge, new value after
      if8.ld_reg = 1'b1;
      if8.dr     = 3'd3;
      if8.bus_in = 16'hAAAA;
      tick();
      if8.bus_in = 16'h5555;
      if8.sr1    = 3'd3;
      #1 check("rdw_before", if8.sr1_out, 16'hAAAA);
      tick();
      if8.ld_reg = 1'b0;
      #1 check("rdw_after", if8.sr1_out, 16'h5555);
      check_state("rdw");
      // condition codes
      if8.ld_cc  = 1'b1;
      if8.bus_in = 16'h8000;
      tick();
      check("cc_neg", {13'h0, if8.n, if8.z, if8.p}, 16'h4);
      if8.bus_in = 16'h0000;
      tick();
      check("cc_zero", {13'h0, if8.n, if8.z, if8.p}, 16'h2);
      if8.bus_in = 16'h7FFF;
      tick();
      check("cc_pos", {13'h0, if8.n, if8.z, if8.p}, 16'h1);
      if8.ld_cc  = 1'b0;
      if8.bus_in = 16'h8000;
      tick();
      check("cc_hold", {13'h0, if8.n, if8.z, if8.p}, 16'h1);
      check_state("cc");
      // hold with bus toggling
      repeat (10) begin
         if8.bus_in = 16'($urandom);
         if8.dr     = 3'($urandom);
         tick();
         check_state("hold");
      end
      // selects beyond NREG on the 6-entry instance
      if8.ld_reg = 1'b1;
      if8.dr     = 3'd7;
      if8.bus_in = 16'hC0DE;
      tick();
      check_state("ill7");
      if8.dr     = 3'd6;
      if8.bus_in = 16'hD00D;
      tick();
      if8.ld_reg = 1'b0;
      check_state("ill6");
      check_reads("ill");
      // reset coincident with a write edge
      if8.ld_reg = 1'b1;
      if8.dr     = 3'd2;
      if8.bus_in = 16'hBEEF;
      @(posedge clk);
      rst_n = 1'b0;
      model_reset();
      #1 check_state("rstwr");
      @(negedge clk);
      if8.ld_reg = 1'b0;
      rst_n = 1'b1;
      tick();
      tick();
      check_state("rstwr_rel");
      check("rstwr_r2", if8.regs_flat[47:32], 16'h0);
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/lc3_regfile.md
# lc3_regfile

Write-side counterpart of the datapath's generic N-way read multiplexer. Decodes a destination-register select and loads the shared 16-bit bus into exactly one of NREG general-purpose registers. Also maintains the LC-3 N/Z/P condition codes. Exposes two combinational read ports plus a flat packed copy of every register, so the existing mux instances (INSIZE=NREG, SELSIZE, DATASIZE) can read it directly.

## Interface
Parameters:
- NREG, 8, number of registers; must be ≤ 2**SELSIZE.
- SELSIZE, 3, width of the register select fields.
- DATASIZE, 16, register and bus width.

Ports:
- clk, input, 1, the single clock; every register updates on its rising edge.
- rst_n, input, 1, reset, asynchronous and active-low.
- ld_reg, input, 1, write enable for the register selected by dr.
- dr, input, SELSIZE, destination register select.
- bus_in, input, DATASIZE, write data from the datapath bus.
- ld_cc, input, 1, load enable for the condition codes, evaluated from bus_in.
- sr1, input, SELSIZE, read port 1 select.
- sr2, input, SELSIZE, read port 2 select.
- sr1_out, output, DATASIZE, contents of R[sr1].
- sr2_out, output, DATASIZE, contents of R[sr2].
- regs_flat, output, DATASIZE*NREG, packed view; R[i] occupies bits [(i+1)*DATASIZE-1 : i*DATASIZE].
- n, z, p, output, 1 each, condition codes.

## Operation
- Reset (rst_n=0):
  - Asynchronously, all R[i] = 0.
  - n=0, z=1, p=0.
  - Reset asserted mid-operation overrides any write in the same cycle.
  - Release is synchronised by the surrounding design; no write occurs on the deasserting edge unless ld_reg is high.
- Write demux:
  - On a rising edge with ld_reg=1 and dr<NREG, R[dr] ← bus_in.
  - All other registers hold.
  - dr≥NREG with ld_reg=1: no register changes.
  - At most one register is written per cycle.
- Condition codes:
  - On a rising edge with ld_cc=1, evaluate bus_in (not the post-write register) as a DATASIZE-bit two's-complement value:
    - MSB=1 → n=1, z=0, p=0.
    - all bits 0 → n=0, z=1, p=0.
    - otherwise → n=0, z=0, p=1.
  - Exactly one of n/z/p is 1 at all times.
  - ld_cc is independent of ld_reg; either, both or neither may be asserted.
- Reads:
  - sr1_out and sr2_out are combinational from current register state.
  - sr1=sr2 is legal; both outputs then carry the same value.
  - sr≥NREG → output 0.
  - There is no write-through bypass: a read of R[dr] in the cycle it is written returns the old value. The new value is visible after the edge.
- regs_flat always mirrors the register array with no added logic.

## Timing
- Write latency: 1 cycle. bus_in sampled at edge k appears on sr*_out and regs_flat immediately after edge k.
- CC latency: 1 cycle, same edge.
- Read path: purely combinational, zero cycles, no registered output stage.
- All state elements are on clk and reset asynchronously on rst_n; no other clocks and no latches.
- Inputs must meet setup to the clk rising edge; rst_n is the only asynchronous input.

## Test plan
- Reset:
  - Drive random values, then pulse rst_n low between edges.
  - All regs_flat = 0, sr1_out = sr2_out = 0, n/z/p = 0/1/0 immediately, before the next edge.
- Demux coverage:
  - For i=0..7, write 16'h1111*i+1 to dr=i.
  - Read back every register on both ports.
  - Each R[i] holds its value, and no other register was disturbed after each write.
- Read-during-write:
  - R3=16'hAAAA; in one cycle set ld_reg=1, dr=3, bus_in=16'h5555, sr1=3.
  - sr1_out = AAAA before the edge and 5555 after it.
- Condition codes:
  - ld_cc with bus_in = 16'h8000 → n=1.
  - ld_cc with bus_in = 16'h0000 → z=1.
  - ld_cc with bus_in = 16'h7FFF → p=1.
  - ld_cc=0 with bus_in=16'h8000 → codes hold.
  - Exactly one flag is set throughout.
- Hold / illegal select:
  - ld_reg=0 with bus_in toggling for 10 cycles → no register changes.
  - With NREG=6, write to dr=7 → no register changes, and sr1=7 reads 0.
- Reset mid-write:
  - Assert rst_n low coincident with an edge where ld_reg=1, dr=2, bus_in=16'hBEEF.
  - R2 = 0 and stays 0 after release.
